banco_registradores_parametrizado: RTL and testbench

//   Parametrised, clocked GPR file for the datapath; successor of the fixed 32x32 two-port bank.

---
 rtl/banco_registradores_parametrizado_pkg.sv | 19 +
 rtl/banco_registradores_parametrizado_porta_leitura.sv | 56 +++++
 rtl/banco_registradores_parametrizado.sv | 136 +++++++++++++
 tb/tb_banco_registradores_parametrizado.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/banco_registradores_parametrizado_pkg.sv
// Shared types and defaults for the parametrised register bank: FSM state encoding,
// default geometry and the helper that locates a port's slice inside a packed bus.
package banco_registradores_pkg;

  typedef enum logic {
    LIMPANDO = 1'b0,
    OPERANDO = 1'b1
  } estado_t;

  localparam int LARGURA_DADO_PADRAO = 32;
  localparam int NUM_REGS_PADRAO     = 32;
  localparam int NUM_LEITURAS_PADRAO = 2;

  // Bit offset of port 'porta' in a bus made of equal 'largura'-bit fields.
  function automatic int deslocamento_porta(input int porta, input int largura);
    return porta * largura;
  endfunction

endpackage

// File: rtl/banco_registradores_parametrizado_porta_leitura.sv
// One registered read port: range check, hardwired-zero mask, write-first bypass
// and the output register. The top feeds it the stored word for its address.
module porta_leitura
  import banco_registradores_pkg::*;
#(
  parameter int LARGURA_DADO  = LARGURA_DADO_PADRAO,
  parameter int NUM_REGS      = NUM_REGS_PADRAO,
  parameter int LARGURA_END   = $clog2(NUM_REGS_PADRAO),
  parameter int REG_ZERO_FIXO = 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  estado_t                 i_estado,
  input  logic [LARGURA_END-1:0]  i_endereco,
  input  logic [LARGURA_DADO-1:0] i_dado_armazenado,
  input  logic                    i_escrita_valida,
  input  logic [LARGURA_END-1:0]  i_endereco_escrita,
  input  logic [LARGURA_DADO-1:0] i_dado_escrita,
  output logic [LARGURA_DADO-1:0] o_dado
);

  localparam logic [LARGURA_END:0] LIMITE_END = (LARGURA_END + 1)'(NUM_REGS);

  logic                    w_endereco_valido;
  logic                    w_bypass;
  logic [LARGURA_DADO-1:0] w_dado_next;
  logic [LARGURA_DADO-1:0] r_dado;

  always_comb begin
    w_endereco_valido = ({1'b0, i_endereco} < LIMITE_END);
    if ((REG_ZERO_FIXO != 0) && (i_endereco == '0)) begin
      w_endereco_valido = 1'b0;
    end
  end

  // A qualified write to this port's address wins over the stored word.
  assign w_bypass = i_escrita_valida && (i_endereco_escrita == i_endereco);

  always_comb begin
    w_dado_next = '0;
    if ((i_estado == OPERANDO) && w_endereco_valido) begin
      w_dado_next = w_bypass ? i_dado_escrita : i_dado_armazenado;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_dado <= '0;
    end else begin
      r_dado <= w_dado_next;
    end
  end

  assign o_dado = r_dado;

endmodule

// File: rtl/banco_registradores_parametrizado.sv
// Parametrised GPR file: storage array, write qualification, sequential clear FSM
// and NUM_LEITURAS registered write-first read ports.
module banco_registradores_parametrizado
  import banco_registradores_pkg::*;
#(
  parameter int  LARGURA_DADO  = LARGURA_DADO_PADRAO,
  parameter int  NUM_REGS      = NUM_REGS_PADRAO,
  parameter int  NUM_LEITURAS  = NUM_LEITURAS_PADRAO,
  parameter int  REG_ZERO_FIXO = 1,
  localparam int LARGURA_END   = $clog2(NUM_REGS)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic                                 uc_escrita,
  input  logic [LARGURA_END-1:0]               endereco_escrita,
  input  logic [LARGURA_DADO-1:0]              dado_p_escrita,
  input  logic [NUM_LEITURAS*LARGURA_END-1:0]  enderecos_leitura,
  output logic [NUM_LEITURAS*LARGURA_DADO-1:0] dados_leitura,
  input  logic                                 limpar,
  output logic                                 ocupado
);

  localparam logic [LARGURA_END-1:0] ULTIMO_REG = LARGURA_END'(NUM_REGS - 1);
  localparam logic [LARGURA_END:0]   LIMITE_END = (LARGURA_END + 1)'(NUM_REGS);

  estado_t                 r_estado;
  estado_t                 w_estado_next;
  logic [LARGURA_END-1:0]  r_contador;
  logic [LARGURA_END-1:0]  w_contador_next;
  logic [LARGURA_DADO-1:0] r_registradores [NUM_REGS];

  logic                    w_escrita_valida;
  logic                    w_mem_we;
  logic [LARGURA_END-1:0]  w_mem_end;
  logic [LARGURA_DADO-1:0] w_mem_dado;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= LIMPANDO;
      r_contador <= '0;
    end else begin
      r_estado   <= w_estado_next;
      r_contador <= w_contador_next;
    end
  end

  always_comb begin
    w_estado_next   = r_estado;
    w_contador_next = r_contador;
    unique case (r_estado)
      LIMPANDO: begin
        if (r_contador == ULTIMO_REG) begin
          w_estado_next   = OPERANDO;
          w_contador_next = '0;
        end else begin
          w_contador_next = r_contador + LARGURA_END'(1);
        end
      end
      OPERANDO: begin
        if (limpar) begin
          w_estado_next   = LIMPANDO;
          w_contador_next = '0;
        end
      end
      default: begin
        w_estado_next   = LIMPANDO;
        w_contador_next = '0;
      end
    endcase
  end

  assign ocupado = (r_estado == LIMPANDO);

  // A clear request takes the cycle, so a write arriving with it is dropped.
  always_comb begin
    w_escrita_valida = 1'b0;
    if ((r_estado == OPERANDO) && !limpar && uc_escrita &&
        ({1'b0, endereco_escrita} < LIMITE_END)) begin
      w_escrita_valida = !((REG_ZERO_FIXO != 0) && (endereco_escrita == '0));
    end
  end

  always_comb begin
    w_mem_we   = 1'b0;
    w_mem_end  = endereco_escrita;
    w_mem_dado = dado_p_escrita;
    if (!reset) begin
      if (r_estado == LIMPANDO) begin
        w_mem_we   = 1'b1;
        w_mem_end  = r_contador;
        w_mem_dado = '0;
      end else begin
        w_mem_we = w_escrita_valida;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_mem_we) begin
      r_registradores[w_mem_end] <= w_mem_dado;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LEITURAS; gi = gi + 1) begin : g_porta
      localparam int OFF_END  = deslocamento_porta(gi, LARGURA_END);
      localparam int OFF_DADO = deslocamento_porta(gi, LARGURA_DADO);

      logic [LARGURA_END-1:0] w_endereco;
      logic [LARGURA_END-1:0] w_indice;

      assign w_endereco = enderecos_leitura[OFF_END +: LARGURA_END];
      // Out-of-range addresses are masked by the port; keep the array index legal.
      assign w_indice   = ({1'b0, w_endereco} < LIMITE_END) ? w_endereco : '0;

      porta_leitura #(
        .LARGURA_DADO (LARGURA_DADO),
        .NUM_REGS     (NUM_REGS),
        .LARGURA_END  (LARGURA_END),
        .REG_ZERO_FIXO(REG_ZERO_FIXO)
      ) u_porta (
        .i_clock           (clock),
        .i_reset           (reset),
        .i_estado          (r_estado),
        .i_endereco        (w_endereco),
        .i_dado_armazenado (r_registradores[w_indice]),
        .i_escrita_valida  (w_escrita_valida),
        .i_endereco_escrita(endereco_escrita),
        .i_dado_escrita    (dado_p_escrita),
        .o_dado            (dados_leitura[OFF_DADO +: LARGURA_DADO])
      );
    end
  endgenerate

endmodule

// File: tb/tb_banco_registradores_parametrizado.sv
// Bench: two bank instances (32x32/2 ports/zero fixed and 24x32/3 ports/zero ordinary)
// share one stimulus stream and are checked every cycle against a behavioural model.
module tb_banco_registradores_parametrizado;

  localparam int LE = 5;
  localparam int LD = 32;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            reset = 1'b1;
  logic            uc_escrita = 1'b0;
  logic            limpar = 1'b0;
  logic [LE-1:0]   endereco_escrita = '0;
  logic [LD-1:0]   dado_p_escrita = '0;
  logic [2*LE-1:0] end_a = '0;
  logic [3*LE-1:0] end_b = '0;
  logic [2*LD-1:0] dados_a;
  logic [3*LD-1:0] dados_b;
  logic            ocupado_a;
  logic            ocupado_b;

  logic [LE-1:0]   ra [3];

  int total = 0;
  int bad   = 0;

  // Model: per-instance geometry, contents, remaining clear cycles, expected reads.
  int            nregs  [2] = '{32, 24};
  int            zfix   [2] = '{1, 0};
  int            nports [2] = '{2, 3};
  logic [LD-1:0] mm     [2][32];
  int            resta  [2];
  logic [LD-1:0] esp_rd [2][3];

  banco_registradores_parametrizado #(
    .LARGURA_DADO(32), .NUM_REGS(32), .NUM_LEITURAS(2), .REG_ZERO_FIXO(1)
  ) dut_a (
    .clock(clock), .reset(reset), .uc_escrita(uc_escrita),
    .endereco_escrita(endereco_escrita), .dado_p_escrita(dado_p_escrita),
    .enderecos_leitura(end_a), .dados_leitura(dados_a),
    .limpar(limpar), .ocupado(ocupado_a)
  );

  banco_registradores_parametrizado #(
    .LARGURA_DADO(32), .NUM_REGS(24), .NUM_LEITURAS(3), .REG_ZERO_FIXO(0)
  ) dut_b (
    .clock(clock), .reset(reset), .uc_escrita(uc_escrita),
    .endereco_escrita(endereco_escrita), .dado_p_escrita(dado_p_escrita),
    .enderecos_leitura(end_b), .dados_leitura(dados_b),
    .limpar(limpar), .ocupado(ocupado_b)
  );

  task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs !== esp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, obs, esp);
    end
  endtask

  task automatic modelo_passo();
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        resta[d] = nregs[d];
        for (int k = 0; k < 3; k++) esp_rd[d][k] = '0;
      end else if (resta[d] > 0) begin
        mm[d][nregs[d] - resta[d]] = '0;
        resta[d]--;
        for (int k = 0; k < 3; k++) esp_rd[d][k] = '0;
      end else begin
        bit valida;
        int wa;
        wa = int'(endereco_escrita);
        valida = !limpar && uc_escrita && (wa < nregs[d]) && !(zfix[d] == 1 && wa == 0);
        for (int k = 0; k < 3; k++) begin
          int a;
          a = int'(ra[k]);
          if (k >= nports[d] || a >= nregs[d] || (zfix[d] == 1 && a == 0))
            esp_rd[d][k] = '0;
          else if (valida && a == wa)
            esp_rd[d][k] = dado_p_escrita;
          else
            esp_rd[d][k] = mm[d][a];
        end
        if (limpar) resta[d] = nregs[d];
        else if (valida) mm[d][wa] = dado_p_escrita;
      end
    end
  endtask

  // Called at a falling edge: apply inputs, advance the model, check after the next edge.
  task automatic ciclo();
    end_a = {ra[1], ra[0]};
    end_b = {ra[2], ra[1], ra[0]};
    modelo_passo();
    @(negedge clock);
    verificar("a_ocupado", {31'b0, ocupado_a}, {31'b0, resta[0] > 0});
    verificar("b_ocupado", {31'b0, ocupado_b}, {31'b0, resta[1] > 0});
    for (int k = 0; k < 2; k++)
      verificar($sformatf("a_rd%0d", k), dados_a[k*LD +: LD], esp_rd[0][k]);
    for (int k = 0; k < 3; k++)
      verificar($sformatf("b_rd%0d", k), dados_b[k*LD +: LD], esp_rd[1][k]);
  endtask

  task automatic ocioso();
    uc_escrita = 1'b0;
    limpar     = 1'b0;
  endtask

  task automatic reset_e_medir(input string tag);
    int na, nb;
    ocioso();
    reset = 1'b1;
    ciclo();
    na = int'(ocupado_a);
    nb = int'(ocupado_b);
    reset = 1'b0;
    repeat (40) begin
      ciclo();
      na += int'(ocupado_a);
      nb += int'(ocupado_b);
    end
    verificar({tag, "_dur_a"}, na, 32);
    verificar({tag, "_dur_b"}, nb, 24);
    $display("clear after reset (%s): busy a=%0d b=%0d cycles", tag, na, nb);
  endtask

  task automatic escrever(input logic [LE-1:0] a, input logic [LD-1:0] v);
    uc_escrita       = 1'b1;
    endereco_escrita = a;
    dado_p_escrita   = v;
    ciclo();
    uc_escrita = 1'b0;
    $display("write x%0d = %h", a, v);
  endtask

  initial begin
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) mm[d][r] = '0;
    for (int k = 0; k < 3; k++) ra[k] = '0;
    @(negedge clock);

    reset_e_medir("inicio");

    escrever(5'd5, 32'hDEADBEEF);
    ra[0] = 5'd5;
    ciclo();
    verificar("le_x5", dados_a[0 +: LD], 32'hDEADBEEF);
    $display("read x5 port0 = %h", dados_a[0 +: LD]);

    escrever(5'd0, 32'hFFFFFFFF);
    ra[0] = 5'd0; ra[1] = 5'd0; ra[2] = 5'd0;
    ciclo();
    verificar("zero_a0", dados_a[0 +: LD], 32'h0);
    verificar("zero_a1", dados_a[LD +: LD], 32'h0);
    verificar("zero_b0", dados_b[0 +: LD], 32'hFFFFFFFF);
    $display("read x0 a=%h b=%h", dados_a[0 +: LD], dados_b[0 +: LD]);

    ra[1] = 5'd7;
    escrever(5'd7, 32'h12345678);
    verificar("bypass_a1", dados_a[LD +: LD], 32'h12345678);
    $display("bypass x7 port1 = %h", dados_a[LD +: LD]);

    escrever(5'd9, 32'h0BADF00D);
    uc_escrita = 1'b1; endereco_escrita = 5'd9; dado_p_escrita = 32'hAAAA5555;
    limpar = 1'b1;
    ciclo();
    limpar = 1'b0;
    for (int i = 0; i < 64 && ocupado_a; i++) begin
      uc_escrita       = 1'b1;
      endereco_escrita = LE'($urandom_range(0, 31));
      dado_p_escrita   = $urandom;
      ciclo();
    end
    verificar("limpeza_fim", {31'b0, ocupado_a}, 32'h0);
    ocioso();
    ra[0] = 5'd5; ra[1] = 5'd9;
    ciclo();
    verificar("pos_limpa_x5", dados_a[0 +: LD], 32'h0);
    verificar("pos_limpa_x9", dados_a[LD +: LD], 32'h0);
    $display("after clear x5=%h x9=%h", dados_a[0 +: LD], dados_a[LD +: LD]);

    limpar = 1'b1;
    ciclo();
    limpar = 1'b0;
    repeat (10) ciclo();
    reset_e_medir("meio");

    escrever(5'd30, 32'hCAFEF00D);
    escrever(5'd3, 32'h33333333);
    escrever(5'd7, 32'h77777777);
    ra[0] = 5'd30; ra[1] = 5'd30; ra[2] = 5'd30;
    ciclo();
    verificar("b_x30_p0", dados_b[0 +: LD], 32'h0);
    verificar("b_x30_p2", dados_b[2*LD +: LD], 32'h0);
    verificar("a_x30_p1", dados_a[LD +: LD], 32'hCAFEF00D);
    ra[0] = 5'd3; ra[1] = 5'd7; ra[2] = 5'd30;
    ciclo();
    verificar("b_ind_p0", dados_b[0 +: LD], 32'h33333333);
    verificar("b_ind_p1", dados_b[LD +: LD], 32'h77777777);
    verificar("b_ind_p2", dados_b[2*LD +: LD], 32'h0);
    $display("independent reads b = %h %h %h",
             dados_b[0 +: LD], dados_b[LD +: LD], dados_b[2*LD +: LD]);

    for (int n = 0; n < 3000; n++) begin
      reset            = ($urandom_range(0, 399) == 0);
      limpar           = ($urandom_range(0, 149) == 0);
      uc_escrita       = ($urandom_range(0, 2) != 0);
      endereco_escrita = LE'($urandom_range(0, 31));
      dado_p_escrita   = $urandom;
      for (int k = 0; k < 3; k++)
        ra[k] = ($urandom_range(0, 3) == 0) ? endereco_escrita : LE'($urandom_range(0, 31));
      ciclo();
    end
    reset = 1'b0;
    ocioso();
    $display("random phase: 3000 cycles");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
